gpio_bank_sched: RTL and testbench
==================================

Name: gpio_bank_sched

Overview:
- Controller that sequences the GPIO_OUT and GPIO_IN register banks on behalf of a host port.
- Replaces the free-running bank counter: host write and read requests arrive on valid/ready channels and are arbitrated round-robin.
- Each granted request becomes a one-hot bank enable, with the correct address and data, to the N output or N input registers.
- Read data returns on a response channel with backpressure.

Parameters:
- WIDTH, 32, data width of every GPIO bank register.
- N, 4, number of GPIO_OUT banks and number of GPIO_IN banks (1..16).
- AW, 2, host address width; must satisfy 2**AW >= N.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  host write request valid.
- wr_ready  output  1  write request accepted when wr_valid & wr_ready at posedge.
- wr_addr  input  AW  target GPIO_OUT bank.
- wr_data  input  WIDTH  data for target bank.
- rd_valid  input  1  host read request valid.
- rd_ready  output  1  read request accepted when rd_valid & rd_ready at posedge.
- rd_addr  input  AW  source GPIO_IN bank.
- rd_resp_valid  output  1  read response valid.
- rd_resp_ready  input  1  host accepts response.
- rd_resp_data  output  WIDTH  read response data.
- out_en  output  N  one-hot write enable to GPIO_OUT banks.
- out_data  output  WIDTH  data bus to GPIO_OUT banks.
- in_en  output  N  one-hot capture enable to GPIO_IN banks.
- in_sel  output  AW  GPIO_IN bank select for the read mux.
- in_data  input  WIDTH  muxed GPIO_IN data, valid one cycle after in_en.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, WRITE, RD_SEL, RD_CAP, RESP. All outputs are registered except wr_ready and rd_ready.
- Reset (sampled at posedge): state=IDLE, out_en=0, in_en=0, out_data=0, in_sel=0, rd_resp_valid=0, rd_resp_data=0, busy=0, prio=WR.
  - wr_ready and rd_ready are forced 0 while reset=1.
  - Reset mid-operation discards any pending write, capture or response; no enable pulses follow.
- Ready generation (combinational):
  - wr_ready = (state==IDLE) & (!rd_valid | prio==WR).
  - rd_ready = (state==IDLE) & (!wr_valid | prio==RD).
  - With neither request valid in IDLE, both readies are 1.
- Arbitration: prio flips to the opposite side after every accepted request. A lone requester is always granted; under contention, grants strictly alternate.
- Write: accepted at edge k -> state WRITE during cycle k+1 with out_en[wr_addr]=1 and out_data=wr_data (captured at k). Returns to IDLE at edge k+1. Exactly one out_en pulse of 1 cycle.
- Read: accepted at edge k.
  - Cycle k+1 RD_SEL: in_sel=rd_addr, in_en[rd_addr]=1.
  - Cycle k+2 RD_CAP: in_en=0, in_sel held; in_data sampled into rd_resp_data at edge k+2.
  - Cycle k+3 RESP: rd_resp_valid=1.
- RESP holds rd_resp_valid and rd_resp_data stable until rd_resp_ready=1 at a posedge, then returns to IDLE.
  - Minimum read latency is 3 cycles accept-to-response.
  - No new request is accepted while in RESP.
- in_sel keeps its last value in IDLE; out_data keeps its last value; enables are 0 outside their pulse state.
- Out-of-range address (addr >= N):
  - Write completes the handshake and visits WRITE with out_en=0.
  - Read completes its full sequence with in_en=0 and rd_resp_data=0.
- Back-to-back: an accept in IDLE may occur at the edge where WRITE returns to IDLE (i.e. a write every 2 cycles max).

Optional Feature:
- Macro: GPIO_BANK_SCHED_ERR_EN.
- With the macro: extra output port err (1 bit), a 1-cycle pulse in the WRITE or RD_SEL cycle of any request whose addr >= N. An extra output err_cnt (8 bits) saturates at 255 and resets to 0.
- Without the macro: neither port exists; out-of-range handling is otherwise identical.

Test Plan:
- Reset then wr_valid, wr_addr=2, wr_data=32'hA5A5_0001 -> wr_ready=1, next cycle out_en=4'b0100, out_data=32'hA5A5_0001 for exactly 1 cycle; busy high that cycle.
- rd_addr=1, in_data driven 32'hDEAD_BEEF -> in_en=4'b0010 and in_sel=1 one cycle after accept; rd_resp_valid=1 with 32'hDEAD_BEEF three cycles after accept.
- wr_valid and rd_valid held high continuously from reset -> first grant write, then read, then write, strictly alternating; no starvation over 8 grants.
- Read with rd_resp_ready=0 for 5 cycles -> rd_resp_valid and rd_resp_data stable, wr_ready/rd_ready=0 throughout; returns to IDLE one edge after rd_resp_ready=1.
- Reset asserted during RD_CAP -> next cycle all outputs at reset values, no rd_resp_valid ever; a subsequent write is granted first (prio=WR).
- With N=3, AW=2, write to addr 3 and read addr 3 -> handshakes complete, out_en=0 and in_en=0 always, response data 0. With GPIO_BANK_SCHED_ERR_EN, err pulses twice and err_cnt=2.

Source files
------------

// File: rtl/gpio_bank_sched_if.sv
// rtl/gpio_bank_sched_if.sv - host request/response channels and GPIO bank bus for gpio_bank_sched
interface gpio_bank_sched_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int AW    = 2
);
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic             rd_resp_valid;
    logic             rd_resp_ready;
    logic [WIDTH-1:0] rd_resp_data;
    logic [N-1:0]     out_en;
    logic [WIDTH-1:0] out_data;
    logic [N-1:0]     in_en;
    logic [AW-1:0]    in_sel;
    logic [WIDTH-1:0] in_data;
    logic             busy;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_resp_ready, in_data,
        input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data, out_en, out_data, in_en, in_sel, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_resp_ready, in_data,
        output wr_ready, rd_ready, rd_resp_valid, rd_resp_data, out_en, out_data, in_en, in_sel, busy
    );
endinterface

// File: rtl/gpio_bank_sched.sv
// rtl/gpio_bank_sched.sv - round-robin GPIO_OUT/GPIO_IN bank sequencer; GPIO_BANK_SCHED_ERR_EN adds err/err_cnt
module gpio_bank_sched #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    gpio_bank_sched_if.slave  bus
`ifdef GPIO_BANK_SCHED_ERR_EN
    ,
    output logic              err,
    output logic [7:0]        err_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_SEL, RD_CAP, RESP} state_t;

    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

    state_t state;
    logic   prio;
    logic   wr_ready_c;
    logic   rd_ready_c;
    logic   wr_acc;
    logic   rd_acc;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < N;
    endfunction

    // Out-of-range addresses decode to no enable at all.
    function automatic logic [N-1:0] onehot(input logic [AW-1:0] a);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(a) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign wr_ready_c   = !reset && (state == IDLE) && (!bus.rd_valid || prio == PRIO_WR);
    assign rd_ready_c   = !reset && (state == IDLE) && (!bus.wr_valid || prio == PRIO_RD);
    assign wr_acc       = bus.wr_valid && wr_ready_c;
    assign rd_acc       = bus.rd_valid && rd_ready_c;
    assign bus.wr_ready = wr_ready_c;
    assign bus.rd_ready = rd_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            prio              <= PRIO_WR;
            bus.out_en        <= '0;
            bus.out_data      <= '0;
            bus.in_en         <= '0;
            bus.in_sel        <= '0;
            bus.rd_resp_valid <= 1'b0;
            bus.rd_resp_data  <= '0;
            bus.busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        state        <= WRITE;
                        prio         <= PRIO_RD;
                        bus.out_en   <= onehot(bus.wr_addr);
                        bus.out_data <= bus.wr_data;
                        bus.busy     <= 1'b1;
                    end else if (rd_acc) begin
                        state      <= RD_SEL;
                        prio       <= PRIO_WR;
                        bus.in_sel <= bus.rd_addr;
                        bus.in_en  <= onehot(bus.rd_addr);
                        bus.busy   <= 1'b1;
                    end
                end
                WRITE: begin
                    state      <= IDLE;
                    bus.out_en <= '0;
                    bus.busy   <= 1'b0;
                end
                RD_SEL: begin
                    state     <= RD_CAP;
                    bus.in_en <= '0;
                end
                RD_CAP: begin
                    // Bank mux output is valid now, one cycle after the capture enable.
                    state             <= RESP;
                    bus.rd_resp_data  <= in_range(bus.in_sel) ? bus.in_data : '0;
                    bus.rd_resp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.rd_resp_ready) begin
                        state             <= IDLE;
                        bus.rd_resp_valid <= 1'b0;
                        bus.busy          <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef GPIO_BANK_SCHED_ERR_EN
    logic acc_oor;

    assign acc_oor = (wr_acc && !in_range(bus.wr_addr)) || (rd_acc && !in_range(bus.rd_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= acc_oor;
            if (acc_oor && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gpio_bank_sched.sv
// tb/tb_gpio_bank_sched.sv - self-checking bench for gpio_bank_sched
module tb_gpio_bank_sched;
    localparam int WIDTH = 32;
    localparam int N     = 3;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gpio_bank_sched_if #(.WIDTH(WIDTH), .N(N), .AW(AW)) bus ();

`ifdef GPIO_BANK_SCHED_ERR_EN
    logic       err;
    logic [7:0] err_cnt;
    gpio_bank_sched #(.WIDTH(WIDTH), .N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus), .err(err), .err_cnt(err_cnt));
`else
    gpio_bank_sched #(.WIDTH(WIDTH), .N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    int n_cmp = 0;
    int n_fail = 0;
    bit exp_prio_wr = 1'b1;
    int exp_err_cnt = 0;

    function automatic logic [N-1:0] exp_en(input int a);
        logic [N-1:0] r;
        r = '0;
        if (a < N) r[a] = 1'b1;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_prio_wr = 1'b1;
        exp_err_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_data = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_en !== '0 || bus.in_en !== '0) begin n_fail++; $display("FAIL reset_en out_en=%b in_en=%b exp 0", bus.out_en, bus.in_en); end
        n_cmp++; if (bus.out_data !== '0 || bus.in_sel !== '0) begin n_fail++; $display("FAIL reset_data out_data=%h in_sel=%0d exp 0", bus.out_data, bus.in_sel); end
        n_cmp++; if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_data !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_resp valid=%b data=%h busy=%b exp 0", bus.rd_resp_valid, bus.rd_resp_data, bus.busy); end
        n_cmp++; if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready wr=%b rd=%b exp 0", bus.wr_ready, bus.rd_ready); end
`ifdef GPIO_BANK_SCHED_ERR_EN
        n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err err=%b cnt=%0d exp 0", err, err_cnt); end
`endif
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready wr=%b rd=%b exp 1", bus.wr_ready, bus.rd_ready); end
    endtask

    task automatic test_write();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        for (int it = 0; it < 5; it++) begin
            a = (it == 0) ? AW'(2) : AW'($urandom_range(0, N - 1));
            d = (it == 0) ? 32'hA5A5_0001 : WIDTH'($urandom);
            @(posedge clk); #1;
            bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
            @(negedge clk);
            n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready it=%0d got %b exp 1", it, bus.wr_ready); end
            @(posedge clk); #1;
            exp_prio_wr = 1'b0;
            bus.wr_valid = 1'b0; bus.wr_data = ~d;
            @(negedge clk);
            n_cmp++; if (bus.out_en !== exp_en(int'(a)) || bus.out_data !== d) begin n_fail++; $display("FAIL wr_pulse it=%0d out_en=%b out_data=%h exp %b %h", it, bus.out_en, bus.out_data, exp_en(int'(a)), d); end
            n_cmp++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_busy it=%0d busy=%b wr_ready=%b exp 1 0", it, bus.busy, bus.wr_ready); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (bus.out_en !== '0 || bus.busy !== 1'b0 || bus.out_data !== d) begin n_fail++; $display("FAIL wr_after it=%0d out_en=%b busy=%b out_data=%h exp 0 0 %h", it, bus.out_en, bus.busy, bus.out_data, d); end
        end
    endtask

    task automatic test_read();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        int               stall;
        for (int it = 0; it < 5; it++) begin
            a = (it == 0) ? AW'(1) : AW'($urandom_range(0, N - 1));
            d = (it == 0) ? 32'hDEAD_BEEF : WIDTH'($urandom);
            stall = (it == 1) ? 5 : $urandom_range(0, 3);
            @(posedge clk); #1;
            bus.rd_valid = 1'b1; bus.rd_addr = a; bus.in_data = d;
            @(negedge clk);
            n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready it=%0d got %b exp 1", it, bus.rd_ready); end
            @(posedge clk); #1;
            exp_prio_wr = 1'b1;
            bus.rd_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.in_en !== exp_en(int'(a)) || bus.in_sel !== a || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_sel it=%0d in_en=%b in_sel=%0d busy=%b exp %b %0d 1", it, bus.in_en, bus.in_sel, bus.busy, exp_en(int'(a)), a); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (bus.in_en !== '0 || bus.in_sel !== a || bus.rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_cap it=%0d in_en=%b in_sel=%0d valid=%b exp 0 %0d 0", it, bus.in_en, bus.in_sel, bus.rd_resp_valid, a); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== d) begin n_fail++; $display("FAIL rd_resp it=%0d valid=%b data=%h exp 1 %h", it, bus.rd_resp_valid, bus.rd_resp_data, d); end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                bus.in_data = WIDTH'($urandom);
                @(negedge clk);
                n_cmp++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== d || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_stall it=%0d s=%0d valid=%b data=%h wr_rdy=%b rd_rdy=%b exp 1 %h 0 0", it, s, bus.rd_resp_valid, bus.rd_resp_data, bus.wr_ready, bus.rd_ready, d); end
            end
            bus.rd_resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rd_resp_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.rd_resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.in_sel !== a) begin n_fail++; $display("FAIL rd_done it=%0d valid=%b busy=%b wr_rdy=%b in_sel=%0d exp 0 0 1 %0d", it, bus.rd_resp_valid, bus.busy, bus.wr_ready, bus.in_sel, a); end
        end
    endtask

    task automatic test_contention();
        int               grants;
        int               cycles;
        logic [AW-1:0]    last_ra;
        logic [WIDTH-1:0] d;
        bit               got_wr;
        bit               got_rd;
        do_reset();
        d = WIDTH'($urandom);
        last_ra = '0;
        bus.in_data = d;
        bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.rd_resp_ready = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, N - 1)); bus.wr_data = WIDTH'($urandom);
        bus.rd_addr = AW'($urandom_range(0, N - 1));
        grants = 0;
        cycles = 0;
        while (grants < 8 && cycles < 200) begin
            @(negedge clk);
            got_wr = bus.wr_ready;
            got_rd = bus.rd_ready;
            if (bus.rd_resp_valid === 1'b1) begin
                n_cmp++; if (bus.rd_resp_data !== d) begin n_fail++; $display("FAIL cont_resp data=%h exp %h", bus.rd_resp_data, d); end
            end
            if (got_wr || got_rd) begin
                n_cmp++; if (got_wr !== exp_prio_wr || got_rd !== !exp_prio_wr) begin n_fail++; $display("FAIL cont_grant n=%0d wr_rdy=%b rd_rdy=%b exp %b %b", grants, got_wr, got_rd, exp_prio_wr, !exp_prio_wr); end
                if (got_rd) last_ra = bus.rd_addr;
                exp_prio_wr = !exp_prio_wr;
                grants++;
            end
            @(posedge clk); #1;
            cycles++;
            if (got_wr) begin bus.wr_addr = AW'($urandom_range(0, N - 1)); bus.wr_data = WIDTH'($urandom); end
            if (got_rd) bus.rd_addr = AW'($urandom_range(0, N - 1));
        end
        n_cmp++; if (grants !== 8) begin n_fail++; $display("FAIL cont_timeout grants=%0d exp 8", grants); end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        cycles = 0;
        while (bus.busy !== 1'b0 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        bus.rd_resp_ready = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cont_drain busy=%b exp 0 last_rd_addr=%0d", bus.busy, last_ra); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        @(posedge clk); #1;
        a = AW'($urandom_range(0, N - 1)); d = WIDTH'($urandom);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got %b exp 1", i, bus.wr_ready); end
            @(posedge clk); #1;
            exp_prio_wr = 1'b0;
            bus.wr_addr = AW'($urandom_range(0, N - 1)); bus.wr_data = WIDTH'($urandom);
            @(negedge clk);
            n_cmp++; if (bus.out_en !== exp_en(int'(a)) || bus.out_data !== d || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse i=%0d out_en=%b out_data=%h wr_rdy=%b exp %b %h 0", i, bus.out_en, bus.out_data, bus.wr_ready, exp_en(int'(a)), d); end
            a = bus.wr_addr; d = bus.wr_data;
            @(posedge clk);
        end
        #1;
        bus.wr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, N - 1));
        @(posedge clk); #1;
        bus.rd_valid = 1'b1; bus.rd_addr = a; bus.in_data = WIDTH'($urandom);
        @(negedge clk);
        n_cmp++; if (bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_acc rd_ready=%b exp 1", bus.rd_ready); end
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_en !== '0 || bus.in_en !== '0 || bus.in_sel !== '0 || bus.out_data !== '0) begin n_fail++; $display("FAIL rst_mid_out out_en=%b in_en=%b in_sel=%0d out_data=%h exp 0", bus.out_en, bus.in_en, bus.in_sel, bus.out_data); end
        n_cmp++; if (bus.rd_resp_valid !== 1'b0 || bus.rd_resp_data !== '0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state valid=%b data=%h busy=%b wr_rdy=%b rd_rdy=%b exp 0", bus.rd_resp_valid, bus.rd_resp_data, bus.busy, bus.wr_ready, bus.rd_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_prio_wr = 1'b1;
        exp_err_cnt = 0;
        @(negedge clk);
        n_cmp++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_prio wr_rdy=%b rd_rdy=%b exp 1 0", bus.wr_ready, bus.rd_ready); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.rd_resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_en !== '0) begin n_fail++; $display("FAIL rst_mid_quiet i=%0d valid=%b busy=%b in_en=%b exp 0", i, bus.rd_resp_valid, bus.busy, bus.in_en); end
        end
    endtask

    task automatic test_out_of_range();
        @(posedge clk); #1;
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(3); bus.wr_data = WIDTH'($urandom);
        @(negedge clk);
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ready got %b exp 1", bus.wr_ready); end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        exp_prio_wr = 1'b0;
        exp_err_cnt++;
        @(negedge clk);
        n_cmp++; if (bus.out_en !== '0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL oor_wr out_en=%b busy=%b exp 0 1", bus.out_en, bus.busy); end
`ifdef GPIO_BANK_SCHED_ERR_EN
        n_cmp++; if (err !== 1'b1 || int'(err_cnt) !== exp_err_cnt) begin n_fail++; $display("FAIL oor_wr_err err=%b cnt=%0d exp 1 %0d", err, err_cnt, exp_err_cnt); end
`endif
        @(posedge clk); #1;
        bus.rd_valid = 1'b1; bus.rd_addr = AW'(3); bus.in_data = WIDTH'($urandom) | 32'h1;
        @(negedge clk);
        n_cmp++; if (bus.rd_ready !== 1'b1 || bus.out_en !== '0) begin n_fail++; $display("FAIL oor_rd_ready rd_rdy=%b out_en=%b exp 1 0", bus.rd_ready, bus.out_en); end
`ifdef GPIO_BANK_SCHED_ERR_EN
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear err=%b exp 0", err); end
`endif
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        exp_prio_wr = 1'b1;
        exp_err_cnt++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.in_en !== '0) begin n_fail++; $display("FAIL oor_rd_en c=%0d in_en=%b exp 0", c, bus.in_en); end
`ifdef GPIO_BANK_SCHED_ERR_EN
            if (c == 1) begin
                n_cmp++; if (err !== 1'b1 || int'(err_cnt) !== exp_err_cnt) begin n_fail++; $display("FAIL oor_rd_err err=%b cnt=%0d exp 1 %0d", err, err_cnt, exp_err_cnt); end
            end
`endif
            if (c < 3) begin @(posedge clk); #1; end
        end
        n_cmp++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_data !== '0) begin n_fail++; $display("FAIL oor_rd_resp valid=%b data=%h exp 1 0", bus.rd_resp_valid, bus.rd_resp_data); end
        bus.rd_resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rd_resp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL oor_done busy=%b valid=%b exp 0 0", bus.busy, bus.rd_resp_valid); end
`ifdef GPIO_BANK_SCHED_ERR_EN
        n_cmp++; if (int'(err_cnt) !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL oor_cnt cnt=%0d err=%b exp 2 0", err_cnt, err); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
